// File: rtl/m_store_buffer.sv
// Posted-write store buffer with youngest-match load forwarding, between MEM-stage stores and data memory.
// Define STORE_BUF_COALESCE_EN to merge a store into the youngest entry when the word addresses match.
module m_store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        st_valid,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        st_ready,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   output logic [31:0] ld_data,
   output logic        ld_hit,
   output logic        ld_stall,
   input  logic        mem_busy,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   output logic        sb_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [29:0]   ent_addr [DEPTH];
   logic [31:0]   ent_data [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW:0]   count;

   logic          full;
   logic          drain;
   logic          alloc;
   logic          coalesce;
   logic          fwd_hit;
   logic [31:0]   fwd_data;
   logic [AW-1:0] idx;
   logic          unused_ok;

   assign unused_ok = ^{st_addr[1:0], ld_addr[1:0]};

   assign full     = (count == (AW+1)'(DEPTH));
   assign sb_empty = (count == '0);
   assign drain    = !sb_empty && !mem_busy && (!ld_valid || full);

`ifdef STORE_BUF_COALESCE_EN
   logic [AW-1:0] youngest;
   assign youngest = tail - AW'(1);
   // Merging into the head while it drains would lose the new data, so that case allocates.
   assign coalesce = st_valid && !sb_empty && (st_addr[31:2] == ent_addr[youngest])
                     && !(drain && (head == youngest));
`else
   assign coalesce = 1'b0;
`endif

   assign st_ready = !full || coalesce;
   assign alloc    = st_valid && !full && !coalesce;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (alloc) tail <= tail + AW'(1);
         if (drain) head <= head + AW'(1);
         case ({alloc, drain})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage carries no reset; occupancy is tracked purely by the pointers and count.
   always_ff @(posedge clk) begin
      if (alloc) begin
         ent_addr[tail] <= st_addr[31:2];
         ent_data[tail] <= st_data;
      end
`ifdef STORE_BUF_COALESCE_EN
      if (coalesce) ent_data[youngest] <= st_data;
`endif
   end

   // Scan oldest to youngest so the last match (closest to tail) wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = mem_read_data;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + AW'(i);
         if (((AW+1)'(i) < count) && (ent_addr[idx] == ld_addr[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = ent_data[idx];
         end
      end
   end

   assign ld_hit         = ld_valid && fwd_hit;
   assign ld_data        = ld_hit ? fwd_data : mem_read_data;
   assign ld_stall       = ld_valid && !ld_hit && (mem_busy || full);

   assign mem_write      = drain;
   assign mem_write_data = ent_data[head];
   assign mem_address    = drain ? {ent_addr[head], 2'b00} : ld_addr;

endmodule
